// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the EX stage of the pipelined MIPS core.
// Multiplies and moves commit in one cycle. Divides take 32 restoring
// iterations on operand magnitudes, followed by one sign-fix/commit cycle.
//
// Handshake: Start is a valid strobe and is sampled only in IDLE while Flush is low.
// Busy is high while a divide is in flight, and a Start seen while Busy is
// dropped. Done pulses for one cycle in the cycle after HI/LO are written.
// Flush aborts an in-flight divide without any write to HI/LO.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic [1:0]            fsm_state
);

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIX = 2'd2
  } state_t;

  state_t state, next_state;

  logic [5:0]     cnt;
  logic [W-1:0]   quo;       // dividend magnitude shifting out, quotient shifting in
  logic [W-1:0]   rem;       // partial remainder
  logic [W-1:0]   dvs;       // divisor magnitude
  logic [W-1:0]   a_hold;    // dividend as presented, for the divide-by-zero result
  logic           neg_q;
  logic           neg_r;
  logic           div_zero;

  logic           accept;
  logic           is_div;
  logic           commit;
  logic           op_signed;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] prod_s;
  logic [2*W-1:0] prod_u;
  logic [W:0]     shifted;
  logic [W:0]     diff;
  logic           qbit;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   fix_hi;
  logic [W-1:0]   fix_lo;

  assign fsm_state = state;

  // Operand decode, products, one restoring-division step and final sign fix.
  always_comb begin
    accept    = (state == S_IDLE) && Start && !Flush;
    is_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    commit    = (state == S_DIV_FIX) && !Flush;
    op_signed = (Op == OP_DIV);
    a_mag     = (op_signed && A[W-1]) ? -A : A;
    b_mag     = (op_signed && B[W-1]) ? -B : B;
    prod_s    = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
    prod_u    = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    shifted   = {rem, quo[W-1]};
    diff      = shifted - {1'b0, dvs};
    qbit      = (shifted >= {1'b0, dvs});
    rem_next  = qbit ? diff[W-1:0] : shifted[W-1:0];
    fix_lo    = div_zero ? {W{1'b1}} : (neg_q ? -quo : quo);
    fix_hi    = div_zero ? a_hold : (neg_r ? -rem : rem);
  end

  // Next-state logic: divide sequencing with Flush abort.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (accept && is_div) next_state = S_DIV_RUN;
      S_DIV_RUN: begin
        if (Flush)              next_state = S_IDLE;
        else if (cnt == 6'd31)  next_state = S_DIV_FIX;
      end
      S_DIV_FIX: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // HI/LO, divider datapath and registered status outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      HI       <= '0;
      LO       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_hold   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      Busy <= (next_state != S_IDLE);
      Done <= 1'b0;
      if (accept) begin
        case (Op)
          OP_MULT:  {HI, LO} <= prod_s;
          OP_MULTU: {HI, LO} <= prod_u;
          OP_MADD:  {HI, LO} <= {HI, LO} + prod_s;
          OP_MSUB:  {HI, LO} <= {HI, LO} - prod_s;
          OP_MTHI:  HI <= A;
          OP_MTLO:  LO <= A;
          default: begin
            quo      <= a_mag;
            dvs      <= b_mag;
            rem      <= '0;
            cnt      <= '0;
            a_hold   <= A;
            neg_q    <= op_signed && (A[W-1] ^ B[W-1]);
            neg_r    <= op_signed && A[W-1];
            div_zero <= (B == '0);
          end
        endcase
        if (!is_div) Done <= 1'b1;
      end
      if ((state == S_DIV_RUN) && !Flush) begin
        rem <= rem_next;
        quo <= {quo[W-2:0], qbit};
        cnt <= cnt + 6'd1;
      end
      if (commit) begin
        HI   <= fix_hi;
        LO   <= fix_lo;
        Done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases with literal results, then
// randomized traffic, all checked each cycle against an arithmetic model.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] r_hi = '0;
  logic [31:0] r_lo = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  longint      sa, sb, sq;
  logic [63:0] tmp;

  hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO),
    .fsm_state(dbg_state)
  );

  // Clock.
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what HI/LO/Busy/Done must be after each edge.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      sa = longint'($signed(A));
      sb = longint'($signed(B));
      if (m_busy) begin
        if (Flush) m_busy = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end else if (Start && !Flush) begin
        m_done = 1'b1;
        case (Op)
          3'd0: {m_hi, m_lo} = sa * sb;
          3'd1: {m_hi, m_lo} = {32'b0, A} * {32'b0, B};
          3'd4: m_hi = A;
          3'd5: m_lo = A;
          3'd6: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
          3'd7: {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
          default: begin
            m_done = 1'b0;
            m_busy = 1'b1;
            m_left = 33;
            if (B == 32'd0) begin
              r_hi = A; r_lo = 32'hFFFFFFFF;
            end else if (Op == 3'd3) begin
              r_lo = A / B; r_hi = A % B;
            end else begin
              sq = sa / sb; tmp = sq; r_lo = tmp[31:0];
              sq = sa % sb; tmp = sq; r_hi = tmp[31:0];
            end
          end
        endcase
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("busy", {63'b0, Busy}, {63'b0, m_busy});
      chk("done", {63'b0, Done}, {63'b0, m_done});
      chk("hi", {32'b0, HI}, {32'b0, m_hi});
      chk("lo", {32'b0, LO}, {32'b0, m_lo});
    end
  end

  task automatic op1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 60) begin
      n++;
      @(negedge Clk);
    end
    if (n >= 60) chk("div_timeout", 64'd1, 64'd0);
  endtask

  task automatic chk_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hi"}, {32'b0, HI}, {32'b0, eh});
    chk({nm, "_lo"}, {32'b0, LO}, {32'b0, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 3'd0; A = '0; B = '0;
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b0;

    // Asynchronous reset clears outputs between edges, including a live Done.
    op1(3'd4, 32'hDEADBEEF, 32'h0);
    chk("mthi_done", {63'b0, Done}, 64'd1);
    #2 Reset = 1'b1;
    #1;
    chk_hilo("areset", 32'h0, 32'h0);
    chk("areset_busy", {63'b0, Busy}, 64'd0);
    chk("areset_done", {63'b0, Done}, 64'd0);
    @(negedge Clk);
    #2 Reset = 1'b0;

    // Multiplies.
    op1(3'd0, 32'hFFFFFFFE, 32'd3);
    chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    chk("mult_done", {63'b0, Done}, 64'd1);
    op1(3'd1, 32'hFFFFFFFE, 32'd3);
    chk_hilo("multu", 32'h00000002, 32'hFFFFFFFA);

    // Divides.
    op1(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", 64'(n), 64'd33);
    chk("div_done", {63'b0, Done}, 64'd1);
    chk_hilo("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    op1(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk_hilo("divu_100_7", 32'd2, 32'd14);
    op1(3'd3, 32'h12345678, 32'h0);
    wait_idle(n);
    chk_hilo("divu_by0", 32'h12345678, 32'hFFFFFFFF);
    op1(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk_hilo("div_ovf", 32'h0, 32'h80000000);

    // Accumulate.
    op1(3'd4, 32'h0, 32'h0);
    op1(3'd5, 32'hFFFFFFFF, 32'h0);
    op1(3'd6, 32'd1, 32'd1);
    chk_hilo("madd", 32'd1, 32'd0);
    op1(3'd7, 32'd2, 32'd1);
    chk_hilo("msub", 32'd0, 32'hFFFFFFFE);

    // Start while busy is ignored; Flush aborts without commit.
    op1(3'd4, 32'hAAAA0000, 32'h0);
    op1(3'd5, 32'h00005555, 32'h0);
    op1(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd5;
    @(negedge Clk);
    Start = 1'b0;
    chk_hilo("ignored_start", 32'hAAAA0000, 32'h00005555);
    repeat (4) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    chk("flush_busy", {63'b0, Busy}, 64'd0);
    chk("flush_done", {63'b0, Done}, 64'd0);
    chk_hilo("flush", 32'hAAAA0000, 32'h00005555);
    repeat (40) @(negedge Clk);
    chk_hilo("flush_late", 32'hAAAA0000, 32'h00005555);

    // Reset mid-divide.
    op1(3'd2, 32'd100, 32'd7);
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk_hilo("reset_mid_div", 32'h0, 32'h0);
    chk("reset_mid_busy", {63'b0, Busy}, 64'd0);
    @(negedge Clk);
    #2 Reset = 1'b0;

    // Randomized traffic, including Start while busy and random Flush.
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      Start = ($urandom_range(0, 2) != 0);
      Op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
      Flush = ($urandom_range(0, 24) == 0);
    end
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    repeat (40) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It sits in the EX stage beside the ALU and executes MULT/MULTU/MADD/MSUB/MTHI/MTLO in one cycle and DIV/DIVU iteratively. It drives the ALUhi/ALUlo values observed at the top level and exposes Busy so hazard logic can interlock MFHI/MFLO and later mul/div issues.

## Interface

- DATA_WIDTH, 32, operand and HI/LO width; the design is verified at 32 only.
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears all state.
- Start  in  1  valid mul/div/move op in EX this cycle; sampled only in IDLE.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- A  in  32  rs operand (dividend / multiplicand / move source).
- B  in  32  rt operand (divisor / multiplier).
- Flush  in  1  kills an in-flight divide (pipeline squash).
- Busy  out  1  registered; high while a divide is in flight.
- Done  out  1  registered one-cycle pulse when HI/LO is committed.
- HI  out  32  registered HI register.
- LO  out  32  registered LO register.

## Operation

- States:
  - IDLE: accepts ops.
  - DIV_RUN: 32 restoring-division iterations on magnitudes, driven by a 6-bit counter.
  - DIV_FIX: sign correction and HI/LO write.
- Reset (asynchronous, any state): state IDLE, HI=0, LO=0, Busy=0, Done=0, counter=0.
- IDLE with Start and no Flush:
  - MULT: {HI,LO} = signed A*B, full 64 bits.
  - MULTU: {HI,LO} = unsigned A*B.
  - MADD: {HI,LO} += signed A*B, mod 2^64.
  - MSUB: {HI,LO} -= signed A*B, mod 2^64.
  - MTHI: HI = A; LO is unchanged.
  - MTLO: LO = A; HI is unchanged.
  - DIV/DIVU: latch the magnitudes of A and B, the sign flags and the op; go to DIV_RUN with counter=0. HI/LO hold until commit.
- DIV_RUN: one quotient bit per cycle. After the 32nd iteration, go to DIV_FIX.
- DIV_FIX: write HI and LO, then go to IDLE.
  - LO = quotient, truncated toward zero. It is negated when the operand signs differ (DIV only).
  - HI = remainder, which takes the sign of the dividend (DIV only).
- Divide by zero, signed or unsigned: normal 33-cycle flow, then HI = A (as presented) and LO = 32'hFFFFFFFF.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO = 32'h80000000, HI = 0 (wraps, no trap).
- Start while Busy is a protocol violation: it is ignored, with no effect on state or HI/LO.
- Flush:
  - In DIV_RUN or DIV_FIX: go to IDLE next edge. HI/LO are unchanged and no Done pulse is produced.
  - In IDLE: suppresses Start that cycle.
  - Flush and Start together: Flush wins.

## Timing

- Single-cycle ops (MULT, MULTU, MADD, MSUB, MTHI, MTLO): Start sampled at edge E0. HI/LO hold the new value after E0, Done is high for the cycle after E0, and Busy stays 0.
- Back-to-back single-cycle ops are legal every cycle. MADD/MSUB accumulate onto the HI/LO written by the previous edge.
- Divide:
  - Start is sampled at E0, and Busy rises after E0.
  - Iterations run at E1..E32; DIV_FIX is active in the cycle following E32.
  - HI/LO are written at E33. Busy falls and Done pulses after E33.
  - Busy is high for exactly 33 cycles; a new Start is accepted at E33 at the earliest... no: earliest at the edge after Busy falls (E34).
- Flush asserted in the cycle before edge Ek: Busy is 0 after Ek. The next Start is accepted at Ek+1.
- Reset asserted mid-divide: HI=LO=0 and Busy=0 immediately (asynchronous), with no Done.
- Outputs are all registered; there is no combinational path from inputs to Busy, Done, HI or LO.

## Test plan

- Reset: assert Reset asynchronously between edges -> HI=0, LO=0, Busy=0, Done=0 immediately.
- Multiply:
  - MULT A=32'hFFFFFFFE, B=3 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA one edge later, single Done pulse.
  - MULTU with the same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- Divide:
  - DIV A=32'hFFFFFFF9 (-7), B=2 -> Busy high exactly 33 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF, Done one cycle.
  - DIVU A=100, B=7 -> LO=14, HI=2.
- Divide corners:
  - DIVU A=32'h12345678, B=0 -> HI=32'h12345678, LO=32'hFFFFFFFF.
  - DIV A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Accumulate: MTHI 0 then MTLO 32'hFFFFFFFF, then MADD A=1, B=1 -> HI=1, LO=0; then MSUB A=2, B=1 -> HI=0, LO=32'hFFFFFFFE.
- Abort cases: MTHI 32'hAAAA0000 and MTLO 32'h00005555, then DIV 100/7.
  - Start MULT at iteration 5 -> ignored.
  - Flush at iteration 10 -> Busy=0 next cycle, no Done, HI/LO keep 32'hAAAA0000 and 32'h00005555.
  - Repeat with Reset mid-divide -> HI=LO=0.
